local_mem_pixel_pp: RTL and testbench

Double-buffered (ping-pong) multi-channel pixel store between the input DMA/wrapper (writer) and the convolution engine (reader). The writer fills one bank one channel-word at a time. The reader fetches all channels of one pixel per access from the other bank. Bank ownership is handed over by a per-bank state machine, so frame N+1 loads while frame N is consumed.

---
 rtl/pixel_mem_pkg.sv | 24 ++
 rtl/pixel_bank.sv | 42 ++++
 rtl/local_mem_pixel_pp.sv | 133 +++++++++++++
 tb/tb_local_mem_pixel_pp.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pixel_mem_pkg.sv
// Shared pixel-store types: bank ownership states and default geometry.
// Reused by the DMA wrapper, the ping-pong store and the conv engine.
package pixel_mem_pkg;

  localparam int PIX_CH    = 3;
  localparam int PIX_DW    = 16;
  localparam int PIX_DEPTH = 1024;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2,
    READ  = 2'd3
  } bank_st_e;

  function automatic logic wr_owned(bank_st_e s);
    return (s == FREE) || (s == FILL);
  endfunction

  function automatic logic rd_owned(bank_st_e s);
    return (s == READY) || (s == READ);
  endfunction

endpackage

// File: rtl/pixel_bank.sv
// One pixel bank: CH lanes x DW bits x DEPTH words.
// Ports: clk/rst, lane-masked write (we_mask/waddr/wdata), sync read
// (re/raddr -> rdata, registered, holds while re is low).
module pixel_bank #(
  parameter int CH    = 3,
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    we_mask,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [CH*DW-1:0] rdata
);

  logic [CH*DW-1:0] mem_q [DEPTH];
  logic [CH*DW-1:0] rdata_q;

  // Storage is never cleared; only the read register resets.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (we_mask[c]) begin
        mem_q[waddr][c*DW +: DW] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/local_mem_pixel_pp.sv
// Ping-pong multi-channel pixel store between writer and conv reader.
// Ports: wr_* channel-word write side, rd_* full-pixel read side, wr_ch_err.
module local_mem_pixel_pp
  import pixel_mem_pkg::*;
#(
  parameter int CH    = PIX_CH,
  parameter int DW    = PIX_DW,
  parameter int DEPTH = PIX_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CW-1:0]    wr_ch,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             wr_last,
  output logic             wr_ch_err,
  output logic             rd_avail,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_valid,
  output logic [CH*DW-1:0] rd_data,
  input  logic rd_done
);

  bank_st_e st_q [2];
  bank_st_e st_d [2];
  logic     wr_sel_q, wr_sel_d;
  logic     rd_sel_q, rd_sel_d;
  logic     err_q, err_d;
  logic     rv_q;
  logic     rbank_q;

  logic             wr_acc;
  logic             ch_ok;
  logic             rd_fire;
  logic             rd_rel;
  logic [CH-1:0]    lane_m;
  logic [CH-1:0]    we0, we1;
  logic [CH*DW-1:0] dout0, dout1;

  assign wr_ready = wr_owned(st_q[wr_sel_q]);
  assign rd_avail = rd_owned(st_q[rd_sel_q]);
  assign wr_acc   = wr_valid && wr_ready;
  assign rd_fire  = rd_req && rd_avail;
  assign rd_rel   = rd_done && rd_avail;
  assign ch_ok    = int'(wr_ch) < CH;

  // Out-of-range lane index decodes to an empty mask.
  always_comb begin
    lane_m = '0;
    for (int c = 0; c < CH; c++) begin
      lane_m[c] = (int'(wr_ch) == c);
    end
  end

  assign we0 = (wr_acc && !wr_sel_q) ? lane_m : '0;
  assign we1 = (wr_acc &&  wr_sel_q) ? lane_m : '0;

  pixel_bank #(
    .CH(CH), .DW(DW), .DEPTH(DEPTH), .AW(AW)
  ) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we_mask (we0),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .re      (rd_fire && !rd_sel_q),
    .raddr   (rd_addr),
    .rdata   (dout0)
  );

  pixel_bank #(
    .CH(CH), .DW(DW), .DEPTH(DEPTH), .AW(AW)
  ) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we_mask (we1),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .re      (rd_fire && rd_sel_q),
    .raddr   (rd_addr),
    .rdata   (dout1)
  );

  // Writer and reader always own different banks, so their
  // updates below never collide on the same entry.
  always_comb begin
    st_d     = st_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    err_d    = err_q;
    if (wr_acc) begin
      st_d[wr_sel_q] = wr_last ? READY : FILL;
      if (wr_last) wr_sel_d = ~wr_sel_q;
      if (!ch_ok)  err_d    = 1'b1;
    end
    if (rd_rel) begin
      st_d[rd_sel_q] = FREE;
      rd_sel_d       = ~rd_sel_q;
    end else if (rd_fire) begin
      st_d[rd_sel_q] = READ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q[0]  <= FREE;
      st_q[1]  <= FREE;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
      rv_q     <= 1'b0;
      rbank_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      err_q    <= err_d;
      rv_q     <= rd_fire;
      if (rd_fire) rbank_q <= rd_sel_q;
    end
  end

  // Bank read registers hold, so the mux output holds too.
  assign rd_data   = rbank_q ? dout1 : dout0;
  assign rd_valid  = rv_q;
  assign wr_ch_err = err_q;

endmodule

// File: tb/tb_local_mem_pixel_pp.sv
// Self-checking bench for local_mem_pixel_pp: directed scenarios plus
// randomized traffic against a frame-count level reference model.
module tb_local_mem_pixel_pp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_ch;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        wr_ch_err;
  logic        rd_avail;
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic        rd_valid;
  logic [47:0] rd_data;
  logic        rd_done;

  local_mem_pixel_pp dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_ch     (wr_ch),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_ch_err (wr_ch_err),
    .rd_avail  (rd_avail),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_done   (rd_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: number of committed (unreleased) frames plus pointers.
  int          ncom;
  bit          wsel, rsel;
  bit          eerr;
  bit          ev;
  logic [15:0] ed [3];
  bit          ek [3];
  logic [15:0] mmem   [2][16][3];
  bit          mknown [2][16][3];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic check_all();
    chk("wr_ready",  64'(wr_ready),  64'(ncom < 2));
    chk("rd_avail",  64'(rd_avail),  64'(ncom > 0));
    chk("rd_valid",  64'(rd_valid),  64'(ev));
    chk("wr_ch_err", 64'(wr_ch_err), 64'(eerr));
    for (int i = 0; i < 3; i++) begin
      if (ek[i]) chk("rd_data_lane", 64'(rd_data[i*16 +: 16]), 64'(ed[i]));
    end
  endtask

  task automatic model_reset();
    ncom = 0; wsel = 0; rsel = 0; eerr = 0; ev = 0;
    for (int i = 0; i < 3; i++) begin
      ed[i] = '0; ek[i] = 1;
    end
  endtask

  task automatic step(input bit v, input int ch, input int a, input int d,
                      input bit lst, input bit rq, input int ra, input bit dn);
    bit acc, avail, commit, rel;
    wr_valid = v;  wr_ch = 2'(ch);  wr_addr = 10'(a);
    wr_data = 16'(d);  wr_last = lst;
    rd_req = rq;  rd_addr = 10'(ra);  rd_done = dn;
    acc   = v && (ncom < 2);
    avail = ncom > 0;
    if (rq && avail) begin
      ev = 1;
      for (int i = 0; i < 3; i++) begin
        ed[i] = mmem[rsel][ra][i];
        ek[i] = mknown[rsel][ra][i];
      end
    end else begin
      ev = 0;
    end
    if (acc && ch < 3) begin
      mmem[wsel][a][ch]   = 16'(d);
      mknown[wsel][a][ch] = 1;
    end
    if (acc && ch >= 3) eerr = 1;
    commit = acc && lst;
    rel    = dn && avail;
    ncom   = ncom + int'(commit) - int'(rel);
    if (commit) wsel = ~wsel;
    if (rel)    rsel = ~rsel;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_step();
    step($urandom_range(0, 9) < 7,
         ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2)),
         int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
         $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
         int'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 16; a++)
        for (int c = 0; c < 3; c++) mknown[b][a][c] = 0;
    rst = 0; wr_valid = 0; wr_ch = 0; wr_addr = 0; wr_data = 0;
    wr_last = 0; rd_req = 0; rd_addr = 0; rd_done = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_wr_ready", 64'(wr_ready), 64'd1);
    chk("reset_rd_data",  64'(rd_data),  64'd0);
    check_all();
    rst = 1;

    // Basic write and read.
    step(1, 0, 5, 16'h0011, 0, 0, 0, 0);
    step(1, 1, 5, 16'h0022, 0, 0, 0, 0);
    step(1, 2, 5, 16'h0033, 1, 0, 0, 0);
    chk("basic_avail", 64'(rd_avail), 64'd1);
    step(0, 0, 0, 0, 0, 1, 5, 0);
    chk("basic_valid", 64'(rd_valid), 64'd1);
    chk("basic_data",  64'(rd_data),  64'h0033_0022_0011);

    // Ping-pong: fill B while reading A.
    step(1, 0, 5, 16'h0101, 0, 1, 5, 0);
    step(1, 1, 5, 16'h0202, 0, 0, 0, 0);
    step(1, 2, 5, 16'h0303, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 5, 0);
    chk("pp_data",     64'(rd_data),  64'h0303_0202_0101);
    chk("pp_wr_ready", 64'(wr_ready), 64'd1);

    // Back-pressure: two committed frames.
    step(1, 0, 7, 16'h0777, 0, 0, 0, 0);
    step(1, 1, 7, 16'h0888, 0, 0, 0, 0);
    step(1, 2, 7, 16'h0999, 1, 0, 0, 0);
    chk("bp_wr_ready", 64'(wr_ready), 64'd0);
    step(1, 0, 7, 16'h1234, 1, 0, 0, 0);
    chk("bp_hold", 64'(wr_ready), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("bp_release", 64'(wr_ready), 64'd1);

    // Read together with release.
    step(0, 0, 0, 0, 0, 1, 7, 1);
    chk("rr_valid", 64'(rd_valid), 64'd1);
    chk("rr_data",  64'(rd_data),  64'h0999_0888_0777);
    chk("rr_freed", 64'(rd_avail), 64'd0);

    // Bad channel index.
    step(1, 0, 2, 16'h0002, 0, 0, 0, 0);
    step(1, 1, 2, 16'h0004, 0, 0, 0, 0);
    step(1, 2, 2, 16'h0006, 0, 0, 0, 0);
    step(1, 3, 2, 16'hFFFF, 1, 0, 0, 0);
    chk("badch_err", 64'(wr_ch_err), 64'd1);
    step(0, 0, 0, 0, 0, 1, 2, 0);
    chk("badch_data", 64'(rd_data), 64'h0006_0004_0002);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("badch_sticky", 64'(wr_ch_err), 64'd1);

    repeat (3000) rnd_step();

    // Reset mid-fill, asynchronous.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 3, 16'h5A5A, 0, 0, 0, 0);
    wr_valid = 0; rd_req = 0; rd_done = 0; wr_last = 0;
    #3 rst = 0;
    #1;
    chk("arst_wr_ready", 64'(wr_ready),  64'd1);
    chk("arst_rd_avail", 64'(rd_avail),  64'd0);
    chk("arst_rd_valid", 64'(rd_valid),  64'd0);
    chk("arst_rd_data",  64'(rd_data),   64'd0);
    chk("arst_err",      64'(wr_ch_err), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    check_all();
    repeat (1000) rnd_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
